tcdm_bank_adapter: RTL and testbench
====================================

TCDM_BANK_ADAPTER -- requirements
Module: tcdm_bank_adapter

Interface
REQ-001 SHALL have parameter NumOutstanding, default 2, meaning the maximum number of accepted requests whose responses have not yet been popped (legal range 1..8).
REQ-002 SHALL have parameter MetaIdWidth, default 4, meaning the width of the requester tag returned with each response.
REQ-003 SHALL have port clk_i, input, 1: clock.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, 1: request valid from the interconnect.
REQ-006 SHALL have port in_ready_o, output, 1: request accepted when in_valid_i && in_ready_o.
REQ-007 SHALL have ports in_addr_i (tcdm_addr_t), in_wen_i (1), in_wdata_i (data_t), in_be_i (be_t), in_meta_i (MetaIdWidth), all inputs: request payload.
REQ-008 SHALL have ports mem_req_o (1), mem_addr_o (tcdm_addr_t), mem_wen_o (1), mem_wdata_o (data_t), mem_be_o (be_t), all outputs: single-cycle bank port toward the tile.
REQ-009 SHALL have port mem_rdata_i, input, data_t: bank read data, valid one cycle after mem_req_o.
REQ-010 SHALL have port resp_valid_o, output, 1: response valid.
REQ-011 SHALL have port resp_ready_i, input, 1: response consumer ready.
REQ-012 SHALL have ports resp_rdata_o (data_t), resp_wen_o (1), resp_meta_o (MetaIdWidth), all outputs: response payload.

Function
REQ-013 SHALL drive in_ready_o = (cnt_q < NumOutstanding), from registered state only; there SHALL be no combinational path from resp_ready_i.
REQ-014 SHALL drive mem_req_o = in_valid_i && in_ready_o, with address, wen, wdata and be passed through combinationally.
REQ-015 SHALL, on accept in cycle T, register vld_q=1, wen_q and meta_q for cycle T+1.
REQ-016 SHALL produce exactly one response per accepted request: reads carry mem_rdata_i sampled at T+1, writes carry rdata '0 and resp_wen_o=1.
REQ-017 SHALL, when vld_q=1 and the FIFO is empty, present the response at T+1 (bypass); if resp_ready_i is also 1, no FIFO push occurs.
REQ-018 SHALL otherwise push {rdata, wen, meta} at T+1 into a FIFO of depth NumOutstanding; the FIFO head drives the response outputs.
REQ-019 SHALL return responses in strict acceptance order.
REQ-020 SHALL drive resp_valid_o = !fifo_empty || vld_q.
REQ-021 SHALL pop (or consume the bypass) on resp_valid_o && resp_ready_i.
REQ-022 SHALL maintain cnt_q: +1 on accept, -1 on response handshake, unchanged when both occur in the same cycle; width $clog2(NumOutstanding+1).
REQ-023 SHALL guarantee that the FIFO never overflows, since the credit bound of REQ-013 covers vld_q plus FIFO occupancy; a push when full SHALL be flagged by an assertion.
REQ-024 SHALL sustain one request per cycle with resp_ready_i held at 1 when NumOutstanding >= 2; with NumOutstanding=1 it SHALL sustain one request per 2 cycles.
REQ-025 SHALL keep response payload stable while resp_valid_o=1 and resp_ready_i=0.

Reset
REQ-026 SHALL, while rst_ni=0, clear cnt_q=0, vld_q=0 and empty the FIFO, giving in_ready_o=1, mem_req_o=0 (for in_valid_i=0) and resp_valid_o=0.
REQ-027 SHALL, on reset mid-operation, discard all in-flight and queued responses with no response issued after reset release.

Structure
REQ-028 SHALL take tcdm_addr_t, data_t, be_t and a new MetaIdWidth constant / meta_id_t typedef from mempool_pkg.
REQ-029 SHALL instantiate exactly one sub-module, fifo_v3 from common_cells, for the response queue; the credit counter and bypass logic SHALL be local.

Verification
REQ-030 SHALL cover single read: write 0xDEADBEEF to addr 0x40, then read 0x40 with meta 3 -> resp_valid_o=1 one cycle after accept, rdata 0xDEADBEEF, meta 3.
REQ-031 SHALL cover back-to-back: 16 reads with resp_ready_i=1 -> in_ready_o stays 1, 16 in-order responses at 1 per cycle.
REQ-032 SHALL cover backpressure: resp_ready_i=0 with 3 requests offered -> 2 accepted, in_ready_o=0 on the third, resp payload stable; release -> third accepted the cycle after the first pop.
REQ-033 SHALL cover simultaneous accept and pop with cnt_q=1 -> cnt_q remains 1, no FIFO overflow assertion fires.
REQ-034 SHALL cover reset asserted with 2 responses queued -> resp_valid_o=0 and in_ready_o=1 after release, and no stale response appears.
REQ-035 SHALL cover write with be=4'b0011, wdata 0x12345678 over 0xFFFFFFFF -> write response rdata 0 with wen=1; a following read returns 0xFFFF5678.

Source files
------------

// File: rtl/mempool_pkg.sv
// Shared MemPool types for the TCDM path: address, data, byte-enable and
// requester tag widths used by the bank adapters.
package mempool_pkg;

  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned BeWidth     = DataWidth / 8;
  localparam int unsigned MetaIdWidth = 4;

  typedef logic [AddrWidth-1:0]   tcdm_addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [BeWidth-1:0]     be_t;
  typedef logic [MetaIdWidth-1:0] meta_id_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO in the common_cells style: head word visible on
// data_o whenever not empty, optional fall-through, synchronous flush.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [AddrDepth-1:0]  rd_ptr_q, wr_ptr_q;
  logic [AddrDepth:0]    cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  is_empty, fall, do_push, do_pop;

  function automatic logic [AddrDepth-1:0] ptr_inc(input logic [AddrDepth-1:0] p);
    return (p == AddrDepth'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_empty = (cnt_q == '0);
  assign full_o   = (cnt_q == (AddrDepth + 1)'(DEPTH));
  assign empty_o  = is_empty && !(FALL_THROUGH && push_i);
  // A fall-through word popped in the same cycle never touches storage.
  assign fall     = FALL_THROUGH && is_empty && push_i && pop_i;
  assign do_push  = push_i && !full_o && !fall;
  assign do_pop   = pop_i && !is_empty;
  assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tcdm_bank_adapter.sv
// Adapts a valid/ready TCDM request stream onto a single-cycle SRAM bank port
// and returns in-order responses, bounded by a credit counter.
module tcdm_bank_adapter
  import mempool_pkg::tcdm_addr_t;
  import mempool_pkg::data_t;
  import mempool_pkg::be_t;
#(
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned MetaIdWidth    = mempool_pkg::MetaIdWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  tcdm_addr_t             in_addr_i,
  input  logic                   in_wen_i,
  input  data_t                  in_wdata_i,
  input  be_t                    in_be_i,
  input  logic [MetaIdWidth-1:0] in_meta_i,
  output logic                   mem_req_o,
  output tcdm_addr_t             mem_addr_o,
  output logic                   mem_wen_o,
  output data_t                  mem_wdata_o,
  output be_t                    mem_be_o,
  input  data_t                  mem_rdata_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output data_t                  resp_rdata_o,
  output logic                   resp_wen_o,
  output logic [MetaIdWidth-1:0] resp_meta_o
);

  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);

  typedef struct packed {
    data_t                  rdata;
    logic                   wen;
    logic [MetaIdWidth-1:0] meta;
  } resp_t;

  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   vld_q, wen_q;
  logic [MetaIdWidth-1:0] meta_q;
  logic                   accept, resp_hs;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  resp_t                  bypass, head, resp;

  // Credits cover the bank stage plus the queue, so the queue cannot overflow.
  assign in_ready_o  = (cnt_q < CntWidth'(NumOutstanding));
  assign accept      = in_valid_i && in_ready_o;

  assign mem_req_o   = accept;
  assign mem_addr_o  = in_addr_i;
  assign mem_wen_o   = in_wen_i;
  assign mem_wdata_o = in_wdata_i;
  assign mem_be_o    = in_be_i;

  always_comb begin
    bypass       = '0;
    bypass.rdata = wen_q ? '0 : mem_rdata_i;
    bypass.wen   = wen_q;
    bypass.meta  = meta_q;
  end

  // Bank data only lives for one cycle, so anything not consumed on the spot
  // is captured; the queue head then takes over the outputs.
  assign fifo_push    = vld_q && !(fifo_empty && resp_ready_i);
  assign fifo_pop     = !fifo_empty && resp_ready_i;
  assign resp_valid_o = !fifo_empty || vld_q;
  assign resp_hs      = resp_valid_o && resp_ready_i;
  assign resp         = fifo_empty ? bypass : head;
  assign resp_rdata_o = resp.rdata;
  assign resp_wen_o   = resp.wen;
  assign resp_meta_o  = resp.meta;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !resp_hs)      cnt_d = cnt_q + CntWidth'(1);
    else if (!accept && resp_hs) cnt_d = cnt_q - CntWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      wen_q  <= 1'b0;
      meta_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= accept;
      if (accept) begin
        wen_q  <= in_wen_i;
        meta_q <= in_meta_i;
      end
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   ($bits(resp_t)),
    .DEPTH        (NumOutstanding)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (bypass),
    .push_i  (fifo_push),
    .data_o  (head),
    .pop_i   (fifo_pop)
  );

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_push && fifo_full))
    else $error("response queue push while full");
`endif

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Directed bench for tcdm_bank_adapter with a transaction-level response model
// and a single-cycle bank stub standing in for the tile SRAM.
module tb_tcdm_bank_adapter;

  localparam int N  = 2;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [31:0]   in_addr = '0, in_wdata = '0;
  logic          in_wen = 1'b0;
  logic [3:0]    in_be = '0;
  logic [MW-1:0] in_meta = '0;
  logic          mem_req, mem_wen;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic          resp_valid, resp_ready = 1'b0, resp_wen;
  logic [31:0]   resp_rdata;
  logic [MW-1:0] resp_meta;

  int checks = 0;
  int errors = 0;
  int n_resp = 0;

  typedef struct {
    logic [31:0]   rdata;
    logic          wen;
    logic [MW-1:0] meta;
  } resp_t;
  resp_t       exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] tile_mem [256];

  tcdm_bank_adapter #(.NumOutstanding(N), .MetaIdWidth(MW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_addr_i    (in_addr),
    .in_wen_i     (in_wen),
    .in_wdata_i   (in_wdata),
    .in_be_i      (in_be),
    .in_meta_i    (in_meta),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_wen_o    (mem_wen),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_rdata_i  (mem_rdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_wen_o   (resp_wen),
    .resp_meta_o  (resp_meta)
  );

  always #5 clk = ~clk;

  // Tile bank stub: byte-masked writes, read data one cycle after the request.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) tile_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= tile_mem[mem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted request owes one response, delivered in order;
  // the credit limit is simply the number of owed responses.
  always @(negedge clk) begin
    resp_t r;
    logic  exp_ready;
    if (!rst_ni) begin
      exp_q.delete();
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      if (!in_valid) chk("rst_mem_req", mem_req, 0);
    end else begin
      exp_ready = (exp_q.size() < N);
      chk("in_ready", in_ready, exp_ready);
      chk("resp_valid", resp_valid, exp_q.size() != 0);
      chk("mem_req", mem_req, in_valid && exp_ready);
      if (in_valid && exp_ready) begin
        chk("mem_addr", mem_addr, in_addr);
        chk("mem_wen", mem_wen, in_wen);
        if (in_wen) begin
          chk("mem_wdata", mem_wdata, in_wdata);
          chk("mem_be", mem_be, in_be);
        end
      end
      if (exp_q.size() != 0) begin
        chk("resp_rdata", resp_rdata, exp_q[0].rdata);
        chk("resp_wen", resp_wen, exp_q[0].wen);
        chk("resp_meta", resp_meta, exp_q[0].meta);
        if (resp_ready) begin
          $display("resp  meta=%0d wen=%0b rdata=%h", exp_q[0].meta, exp_q[0].wen, exp_q[0].rdata);
          void'(exp_q.pop_front());
          n_resp++;
        end
      end
      if (in_valid && exp_ready) begin
        r.wen  = in_wen;
        r.meta = in_meta;
        if (in_wen) begin
          for (int b = 0; b < 4; b++)
            if (in_be[b]) ref_mem[in_addr[9:2]][8*b +: 8] = in_wdata[8*b +: 8];
          r.rdata = '0;
        end else begin
          r.rdata = ref_mem[in_addr[9:2]];
        end
        $display("req   addr=%h wen=%0b wdata=%h be=%b meta=%0d", in_addr, in_wen, in_wdata, in_be, in_meta);
        exp_q.push_back(r);
      end
    end
  end

  task automatic set_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] be, input logic [3:0] m);
    in_valid = 1'b1;
    in_addr  = a;
    in_wen   = w;
    in_wdata = d;
    in_be    = be;
    in_meta  = m;
  endtask

  // Offer one request and return at posedge+1 right after it is accepted.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] be, input logic [3:0] m);
    bit done = 1'b0;
    set_req(a, w, d, be, m);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual=not_accepted expected=accepted addr=%h", a);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int          base;
    logic [31:0] held;
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [31:0] held;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    resp_ready = 1'b1;

    // Single write then read of the same word.
    do_req(32'h40, 1'b1, 32'hDEADBEEF, 4'hF, 4'd1);
    do_req(32'h40, 1'b0, 32'h0, 4'hF, 4'd3);
    @(negedge clk);
    chk("single_valid", resp_valid, 1);
    chk("single_rdata", resp_rdata, 32'hDEADBEEF);
    chk("single_meta", resp_meta, 3);
    @(posedge clk); #1;

    // Preload 16 words back to back, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      set_req(32'h100 + 4 * i, 1'b1, 32'h11111111 * (i + 1), 4'hF, 4'(i));
      @(negedge clk);
      chk("b2b_wr_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    base = n_resp;
    for (int i = 0; i < 16; i++) begin
      set_req(32'h100 + 4 * i, 1'b0, 32'h0, 4'hF, 4'(15 - i));
      @(negedge clk);
      chk("b2b_rd_ready", in_ready, 1);
      if (i > 0) chk("b2b_rd_valid", resp_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("b2b_resp_count", n_resp - base, 16);

    // Backpressure: two accepted, third stalls until the first pop frees a credit.
    resp_ready = 1'b0;
    set_req(32'h100, 1'b0, 32'h0, 4'hF, 4'd5);
    @(negedge clk); chk("bp_first_ready", in_ready, 1);
    @(posedge clk); #1;
    set_req(32'h104, 1'b0, 32'h0, 4'hF, 4'd6);
    @(negedge clk); chk("bp_second_ready", in_ready, 1);
    @(posedge clk); #1;
    set_req(32'h108, 1'b0, 32'h0, 4'hF, 4'd7);
    @(negedge clk);
    chk("bp_third_blocked", in_ready, 0);
    chk("bp_head_rdata", resp_rdata, 32'h11111111);
    held = resp_rdata;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_still_blocked", in_ready, 0);
      chk("bp_stable_rdata", resp_rdata, held);
      chk("bp_stable_meta", resp_meta, 5);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk); chk("bp_release_cycle_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_third_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Accept and pop in the same cycle with one outstanding keeps the count.
    do_req(32'h10C, 1'b0, 32'h0, 4'hF, 4'd2);
    set_req(32'h110, 1'b0, 32'h0, 4'hF, 4'd4);
    @(negedge clk);
    chk("same_cycle_valid", resp_valid, 1);
    chk("same_cycle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("same_cycle_after_ready", in_ready, 1);
    chk("same_cycle_after_rdata", resp_rdata, 32'h55555555);
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Reset with two responses queued: nothing stale may surface afterwards.
    resp_ready = 1'b0;
    do_req(32'h40, 1'b0, 32'h0, 4'hF, 4'd8);
    do_req(32'h104, 1'b0, 32'h0, 4'hF, 4'd9);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", resp_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    repeat (4) @(posedge clk); #1;

    // Byte-masked write over an all-ones word.
    do_req(32'h80, 1'b1, 32'hFFFFFFFF, 4'hF, 4'd1);
    do_req(32'h80, 1'b1, 32'h12345678, 4'b0011, 4'd2);
    @(negedge clk);
    chk("be_wr_rdata", resp_rdata, 32'h0);
    chk("be_wr_wen", resp_wen, 1);
    chk("be_wr_meta", resp_meta, 2);
    @(posedge clk); #1;
    do_req(32'h80, 1'b0, 32'h0, 4'hF, 4'd4);
    @(negedge clk);
    chk("be_rd_rdata", resp_rdata, 32'hFFFF5678);
    chk("be_rd_wen", resp_wen, 0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
